// File: rtl/flop_arb_pkg.sv
// Shared widths, FSM state type and write-beat payload for the flop bank arbiter.
package flop_arb_pkg;

  localparam int unsigned NREQ     = 4;
  localparam int unsigned DW       = 8;
  localparam int unsigned NREG     = 4;
  localparam int unsigned AW       = 2;
  localparam int unsigned MAX_LOCK = 8;

  localparam int unsigned RW  = $clog2(NREQ);
  localparam int unsigned LCW = $clog2(MAX_LOCK);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT  = 2'd1,
    ST_LOCKED = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_beat_t;

endpackage

// File: rtl/flop_en.sv
// Loadable register with asynchronous active-low clear; one per bank entry.
module flop_en #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_o <= '0;
    end else if (en_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/flop_bank_arbiter.sv
// Round-robin write arbiter with bounded locking, owning a bank of registers
// exposed through two combinational read ports.
module flop_bank_arbiter
  import flop_arb_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_i,
  input  logic [NREQ-1:0]      lock_i,
  input  logic [NREQ*AW-1:0]   wr_addr_i,
  input  logic [NREQ*DW-1:0]   wr_data_i,
  output logic [NREQ-1:0]      gnt_o,
  output logic                 busy_o,
  input  logic [AW-1:0]        rd_addr0_i,
  input  logic [AW-1:0]        rd_addr1_i,
  output logic [DW-1:0]        rd_data0_o,
  output logic [DW-1:0]        rd_data1_o
);

  arb_state_e      state_q, state_d;
  logic [RW-1:0]   owner_q, owner_d;
  logic [RW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [LCW-1:0]  lock_cnt_q, lock_cnt_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            busy_q, busy_d;

  logic            keep;
  logic [RW-1:0]   search_ptr;
  logic [RW:0]     pick;

  wr_beat_t        beat;
  logic            wr_fire;
  logic [DW-1:0]   bank [NREG];

  // First requester at or after ptr, wrapping; returns {found, index}.
  function automatic logic [RW:0] rr_pick(input logic [NREQ-1:0] r,
                                          input logic [RW-1:0]   ptr);
    logic [RW:0]   res;
    logic [RW-1:0] idx;
    res = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = ptr + RW'(k);
      if (!res[RW] && r[idx]) begin
        res = {1'b1, idx};
      end
    end
    return res;
  endfunction

  // Next-state: hold a locked owner until its beat budget runs out, else re-arbitrate.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    lock_cnt_d = lock_cnt_q;
    search_ptr = rr_ptr_q;
    pick       = '0;

    keep = (state_q != ST_IDLE) && req_i[owner_q] && lock_i[owner_q] &&
           (lock_cnt_q < LCW'(MAX_LOCK - 1));

    if (keep) begin
      state_d    = ST_LOCKED;
      lock_cnt_d = lock_cnt_q + LCW'(1);
    end else begin
      if (state_q != ST_IDLE) begin
        search_ptr = owner_q + RW'(1);
        rr_ptr_d   = search_ptr;
        lock_cnt_d = '0;
      end
      pick = rr_pick(req_i, search_ptr);
      if (pick[RW]) begin
        state_d = ST_GRANT;
        owner_d = pick[RW-1:0];
      end else begin
        state_d = ST_IDLE;
      end
    end

    busy_d = (state_d != ST_IDLE);
    gnt_d  = busy_d ? (NREQ'(1) << owner_d) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      lock_cnt_q <= '0;
      gnt_q      <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_cnt_q <= lock_cnt_d;
      gnt_q      <= gnt_d;
      busy_q     <= busy_d;
    end
  end

  assign gnt_o  = gnt_q;
  assign busy_o = busy_q;

  // Only the current owner can write, so its lanes alone feed the bank.
  assign beat.addr = wr_addr_i[32'(owner_q)*AW +: AW];
  assign beat.data = wr_data_i[32'(owner_q)*DW +: DW];
  assign wr_fire   = |(gnt_q & req_i);

  for (genvar g = 0; g < NREG; g++) begin : g_bank
    flop_en #(.W(DW)) u_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .en_i  (wr_fire && (beat.addr == AW'(g))),
      .d_i   (beat.data),
      .q_o   (bank[g])
    );
  end

  assign rd_data0_o = bank[rd_addr0_i];
  assign rd_data1_o = bank[rd_addr1_i];

endmodule

// File: tb/tb_flop_bank_arbiter.sv
// Directed and randomized bench for flop_bank_arbiter against a behavioural
// model of grants, fairness pointer, lock budget and bank contents.
module tb_flop_bank_arbiter;

  localparam int MAXL = 8;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [3:0]  lock;
  logic [1:0]  wa [4];
  logic [7:0]  wd [4];
  logic [7:0]  wr_addr_bus;
  logic [31:0] wr_data_bus;
  logic [3:0]  gnt;
  logic        busy;
  logic [1:0]  rd_addr0, rd_addr1;
  logic [7:0]  rd_data0, rd_data1;

  int checks   = 0;
  int failures = 0;

  // Model: current owner (-1 when idle), search start, beats held, bank image.
  int         m_owner;
  int         m_ptr;
  int         m_run;
  logic [7:0] m_bank [4];

  assign wr_addr_bus = {wa[3], wa[2], wa[1], wa[0]};
  assign wr_data_bus = {wd[3], wd[2], wd[1], wd[0]};

  flop_bank_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_i      (req),
    .lock_i     (lock),
    .wr_addr_i  (wr_addr_bus),
    .wr_data_i  (wr_data_bus),
    .gnt_o      (gnt),
    .busy_o     (busy),
    .rd_addr0_i (rd_addr0),
    .rd_addr1_i (rd_addr1),
    .rd_data0_o (rd_data0),
    .rd_data1_o (rd_data1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] exp_gnt();
    return (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_run   = 0;
    for (int i = 0; i < 4; i++) m_bank[i] = 8'h00;
  endtask

  // One clock edge of the arbiter as described by its rules.
  task automatic model_edge();
    int w;
    if (m_owner >= 0 && req[m_owner]) m_bank[wa[m_owner]] = wd[m_owner];
    if (m_owner >= 0 && req[m_owner] && lock[m_owner] && m_run < MAXL) begin
      m_run++;
      return;
    end
    if (m_owner >= 0) m_ptr = (m_owner + 1) % 4;
    w = -1;
    for (int k = 0; k < 4; k++) begin
      if (w < 0 && req[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
    end
    m_owner = w;
    m_run   = (w >= 0) ? 1 : 0;
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check({tag, ".gnt"},  32'(gnt),      32'(exp_gnt()));
    check({tag, ".busy"}, 32'(busy),     32'(m_owner >= 0));
    check({tag, ".rd0"},  32'(rd_data0), 32'(m_bank[rd_addr0]));
    check({tag, ".rd1"},  32'(rd_data1), 32'(m_bank[rd_addr1]));
  endtask

  task automatic clear_inputs();
    req  = '0;
    lock = '0;
    for (int i = 0; i < 4; i++) begin
      wa[i] = '0;
      wd[i] = '0;
    end
  endtask

  task automatic do_reset(input string tag);
    clear_inputs();
    rst_n = 1'b0;
    #1;
    model_reset();
    check({tag, ".gnt"},  32'(gnt),  32'h0);
    check({tag, ".busy"}, 32'(busy), 32'h0);
    for (int a = 0; a < 4; a++) begin
      rd_addr0 = 2'(a);
      rd_addr1 = 2'(3 - a);
      #1;
      check({tag, ".rd0"}, 32'(rd_data0), 32'h0);
      check({tag, ".rd1"}, 32'(rd_data1), 32'h0);
    end
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    clear_inputs();
    rd_addr0 = '0;
    rd_addr1 = '0;
    rst_n    = 1'b0;
    model_reset();

    do_reset("reset");

    // Single write from requester 2, held until its granted beat completes.
    req[2] = 1'b1; wa[2] = 2'd3; wd[2] = 8'hA5; rd_addr0 = 2'd3; rd_addr1 = 2'd0;
    step("sw.grant");
    check("sw.gnt0100", 32'(gnt), 32'h4);
    check("sw.old",     32'(rd_data0), 32'h00);
    step("sw.write");
    check("sw.data", 32'(rd_data0), 32'hA5);
    req = '0;
    step("sw.drop");
    check("sw.idle", 32'(busy), 32'h0);

    // Empty beat: grant without req must not write.
    req[1] = 1'b1; wa[1] = 2'd1; wd[1] = 8'h3C; rd_addr1 = 2'd1;
    step("eb.grant");
    check("eb.gnt0010", 32'(gnt), 32'h2);
    req = '0;
    step("eb.empty");
    check("eb.nowrite", 32'(rd_data1), 32'h00);
    check("eb.idle",    32'(busy),     32'h0);

    // Round robin across all four requesters to address 0.
    do_reset("rr.rst");
    req = 4'b1111; rd_addr0 = 2'd0;
    for (int i = 0; i < 4; i++) begin
      wa[i] = 2'd0;
      wd[i] = 8'(8'h10 + i);
    end
    for (int k = 0; k < 8; k++) begin
      step("rr");
      check("rr.seq", 32'(gnt), 32'(1 << (k % 4)));
    end
    step("rr.last");
    check("rr.bank0", 32'(rd_data0), 32'h13);
    req = '0;
    step("rr.end");

    // Lock bound: requester 0 keeps the bus for exactly MAX_LOCK beats.
    do_reset("lk.rst");
    req = 4'b0011; lock = 4'b0001; wa[0] = 2'd2; wd[0] = 8'h5A; wa[1] = 2'd1; wd[1] = 8'hC3;
    rd_addr0 = 2'd2; rd_addr1 = 2'd1;
    for (int k = 0; k < MAXL; k++) begin
      step("lk");
      check("lk.hold", 32'(gnt), 32'h1);
    end
    step("lk.rel");
    check("lk.release", 32'(gnt), 32'h2);
    req = '0; lock = '0;
    step("lk.end");

    // Reset in the middle of a lock with a different beat pending.
    do_reset("ml.rst");
    req = 4'b0011; lock = 4'b0001; wa[0] = 2'd2; wd[0] = 8'h5A; rd_addr0 = 2'd2;
    step("ml.a");
    step("ml.b");
    step("ml.c");
    check("ml.pre", 32'(rd_data0), 32'h5A);
    wd[0] = 8'h77;
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check("ml.gnt",  32'(gnt),      32'h0);
    check("ml.busy", 32'(busy),     32'h0);
    check("ml.bank", 32'(rd_data0), 32'h00);
    @(posedge clk);
    #1;
    check("ml.nowrite", 32'(rd_data0), 32'h00);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    req = 4'b1111; lock = '0;
    step("ml.post");
    check("ml.first", 32'(gnt), 32'h1);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      req  = 4'($urandom);
      lock = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b1111;
      for (int i = 0; i < 4; i++) begin
        wa[i] = 2'($urandom);
        wd[i] = 8'($urandom);
      end
      rd_addr0 = 2'($urandom);
      rd_addr1 = 2'($urandom);
      step("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
